line_mem_responder: RTL and testbench

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/line_mem_responder_if.sv | 34 +++
 rtl/line_mem_responder.sv | 137 +++++++++++++
 tb/tb_line_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_responder_if.sv
// Line memory bus between a requester (master) and the line memory
// responder (slave).
//   mem_read  : line read request, held until mem_ready
//   mem_write : line write request, held until mem_ready
//   mem_addr  : line address [31:4]
//   mem_wdata : 128-bit write line data
//   mem_rdata : 128-bit read line data, valid with mem_ready after a read
//   mem_ready : single-cycle completion pulse
interface line_mem_responder_if;
    logic          mem_read;
    logic          mem_write;
    logic [31:4]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency 128-bit line memory responder.
// Accepts one read or write request at a time, completes it LATENCY cycles
// after acceptance with a one-cycle mem_ready pulse, then idles one GAP cycle
// before accepting the next request. Dropping the request while BUSY aborts.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset (storage array is not cleared)
//   bus   : line_mem_responder_if.slave (read/write/addr/wdata in,
//           rdata/ready out)
// Parameters:
//   LATENCY    : cycles from accepting edge to mem_ready (1..255)
//   DEPTH_LOG2 : log2 of the number of stored lines (1..28)
module line_mem_responder #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_mem_responder_if.slave  bus
);

    localparam int unsigned LINES = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]            state;
    logic [7:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wr_q;
    logic [127:0]          wdata_q;
    logic [127:0]          rdata_q;
    logic                  ready_q;

    logic [127:0]          mem [LINES];

    logic                  req;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  unused_addr;

    // Completion of the current transaction on this edge (entering RESP).
    logic                  done;
    logic                  done_wr;
    logic [DEPTH_LOG2-1:0] done_idx;
    logic [127:0]          done_wdata;

    assign req         = bus.mem_read | bus.mem_write;
    assign req_idx     = bus.mem_addr[DEPTH_LOG2+3:4];
    // Upper line-address bits alias onto the same line.
    assign unused_addr = ^bus.mem_addr;

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;

    // With LATENCY=1 the accepting edge is also the completing edge, so the
    // live bus values are used instead of the (not yet latched) copies.
    always_comb begin
        done       = 1'b0;
        done_wr    = wr_q;
        done_idx   = idx_q;
        done_wdata = wdata_q;
        case (state)
            S_IDLE: begin
                if (req && (LATENCY == 1)) begin
                    done       = 1'b1;
                    done_wr    = bus.mem_write;
                    done_idx   = req_idx;
                    done_wdata = bus.mem_wdata;
                end
            end
            S_BUSY: begin
                if (req && (cnt == 8'd1)) begin
                    done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // RESP is entered on the edge that counts down to zero, so a counter
    // loaded with LATENCY-1 yields mem_ready in the LATENCY-th cycle after
    // acceptance, lining up with the LATENCY=1 case that skips BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q   <= req_idx;
                        wr_q    <= bus.mem_write;   // read+write counts as write
                        wdata_q <= bus.mem_wdata;
                        cnt     <= 8'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!req) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == 8'd1) begin
                        state <= S_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: state <= S_GAP;
                S_GAP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (done) begin
                ready_q <= 1'b1;
                if (!done_wr) begin
                    rdata_q <= mem[done_idx];
                end
            end
        end
    end

    // Storage has no reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && done && done_wr) begin
            mem[done_idx] <= done_wdata;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed vector table,
// hand-written multi-cycle sequences (reset, abort, address change, reset in
// BUSY/RESP, held re-accept) and random traffic against a line-level model.
module tb_line_mem_responder;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rd_v [3];
    logic         wr_v [3];
    logic [31:4]  addr;
    logic [127:0] wdata;

    line_mem_responder_if b8 ();
    line_mem_responder_if b1 ();
    line_mem_responder_if b255 ();

    assign b8.mem_read    = rd_v[0];
    assign b8.mem_write   = wr_v[0];
    assign b8.mem_addr    = addr;
    assign b8.mem_wdata   = wdata;
    assign b1.mem_read    = rd_v[1];
    assign b1.mem_write   = wr_v[1];
    assign b1.mem_addr    = addr;
    assign b1.mem_wdata   = wdata;
    assign b255.mem_read  = rd_v[2];
    assign b255.mem_write = wr_v[2];
    assign b255.mem_addr  = addr;
    assign b255.mem_wdata = wdata;

    line_mem_responder #(.LATENCY(8), .DEPTH_LOG2(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );
    line_mem_responder #(.LATENCY(1), .DEPTH_LOG2(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    line_mem_responder #(.LATENCY(255), .DEPTH_LOG2(4)) dut255 (
        .clk(clk), .rst_n(rst_n), .bus(b255)
    );

    logic ready_v [3];
    assign ready_v[0] = b8.mem_ready;
    assign ready_v[1] = b1.mem_ready;
    assign ready_v[2] = b255.mem_ready;

    // Reference model: line contents by index, last value read back.
    logic [127:0] model_mem [int];
    int           known [$];
    logic [127:0] last_rd;

    localparam logic [127:0] C0 = {16{8'hC0}};
    localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1 = 128'hDEADBEEF00000003CAFEF00D12345678;
    localparam logic [127:0] D2 = 128'h77770007F00DFACE0BADC0DE13572468;
    localparam logic [127:0] AA = {32{4'hA}};
    localparam logic [127:0] V5 = {32{4'h5}};
    localparam logic [127:0] E0 = {16{8'hE0}};
    localparam logic [127:0] F0 = {16{8'hF0}};

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:4]  a;
        logic [127:0] d;
        logic [127:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model of a completed transaction: returns expected mem_rdata at ready.
    task automatic model_apply(input logic rd, input logic wr, input logic [31:4] a,
                               input logic [127:0] d, output logic [127:0] exp_rd);
        int idx;
        idx = int'(a[11:4]);
        if (wr) begin
            if (!model_mem.exists(idx)) known.push_back(idx);
            model_mem[idx] = d;
        end else if (rd) begin
            last_rd = model_mem.exists(idx) ? model_mem[idx] : '0;
        end
        exp_rd = last_rd;
    endtask

    // One transaction on the LATENCY=8 instance; starts and ends on a negedge
    // with the responder idle.
    task automatic txn(input logic rd, input logic wr, input logic [31:4] a,
                       input logic [127:0] d, input bit perturb,
                       input logic [127:0] exp_rd, input string name);
        int n;
        bit got;
        rd_v[0] = rd;
        wr_v[0] = wr;
        addr    = a;
        wdata   = d;
        n   = 0;
        got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (b8.mem_ready) got = 1;
            else if (perturb && n == 2) begin
                addr    = a ^ 28'h2;
                wdata   = ~d;
                rd_v[0] = wr;
                wr_v[0] = rd;
            end
        end
        check_int({name, " latency"}, got ? n : -1, 8);
        if (got) check_val({name, " rdata"}, b8.mem_rdata, exp_rd);
        rd_v[0] = 1'b0;
        wr_v[0] = 1'b0;
        @(negedge clk);
        check_bit({name, " ready low after"}, b8.mem_ready, 1'b0);
        @(negedge clk);
    endtask

    task automatic lat_meas(input int w, input int lat, input string name);
        int n;
        bit got;
        rd_v[w] = 1'b1;
        addr    = 28'h1;
        n   = 0;
        got = 0;
        while (!got && n < lat + 20) begin
            @(negedge clk);
            n++;
            if (ready_v[w]) got = 1;
        end
        check_int({name, " latency"}, got ? n : -1, lat);
        rd_v[w] = 1'b0;
        @(negedge clk);
        check_bit({name, " ready low after"}, ready_v[w], 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [127:0] e;
        logic [31:4]  a;
        logic [127:0] d;
        int           n;
        bit           got;
        int           op;

        for (int i = 0; i < 3; i++) begin
            rd_v[i] = 1'b0;
            wr_v[i] = 1'b0;
        end
        addr    = '0;
        wdata   = '0;
        last_rd = '0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("reset ready", b8.mem_ready, 1'b0);
        check_val("reset rdata", b8.mem_rdata, '0);
        rst_n = 1'b1;

        // Known contents for the post-reset read (storage survives reset).
        model_apply(1'b0, 1'b1, 28'h20, C0, e);
        txn(1'b0, 1'b1, 28'h20, C0, 0, e, "prewrite");

        // Reset held 2 cycles with mem_read asserted, then released.
        rd_v[0] = 1'b1;
        addr    = 28'h20;
        rst_n   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_bit("in-reset ready", b8.mem_ready, 1'b0);
            check_val("in-reset rdata", b8.mem_rdata, '0);
        end
        rst_n   = 1'b1;
        last_rd = '0;
        model_apply(1'b1, 1'b0, 28'h20, '0, e);
        txn(1'b1, 1'b0, 28'h20, '0, 0, e, "post-reset read");

        vecs[0] = '{1'b0, 1'b1, 28'h10,   D0, C0};
        vecs[1] = '{1'b1, 1'b0, 28'h10,   '0, D0};
        vecs[2] = '{1'b1, 1'b1, 28'h3,    D1, D0};
        vecs[3] = '{1'b1, 1'b0, 28'h103,  '0, D1};
        vecs[4] = '{1'b0, 1'b1, 28'h7,    D2, D1};
        vecs[5] = '{1'b1, 1'b0, 28'h7,    '0, D2};
        vecs[6] = '{1'b0, 1'b1, 28'h5,    AA, D2};
        vecs[7] = '{1'b1, 1'b0, 28'h1005, '0, AA};
        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 0, vecs[i].exp_rd,
                $sformatf("vec%0d", i));
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, e);
        end

        // Abort: write dropped after 3 cycles leaves line 5 untouched.
        wr_v[0] = 1'b1;
        addr    = 28'h5;
        wdata   = V5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("abort busy ready", b8.mem_ready, 1'b0);
        end
        wr_v[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_bit("abort after ready", b8.mem_ready, 1'b0);
        end
        txn(1'b1, 1'b0, 28'h5, '0, 0, AA, "abort readback");

        // Address/data/op change after acceptance is ignored.
        txn(1'b1, 1'b0, 28'h7, '0, 1, D2, "addr change");
        last_rd = D2;

        // Reset during BUSY: no commit, rdata cleared.
        model_apply(1'b0, 1'b1, 28'h40, E0, e);
        txn(1'b0, 1'b1, 28'h40, E0, 0, e, "prewrite 40");
        wr_v[0] = 1'b1;
        addr    = 28'h40;
        wdata   = F0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b0;
        wr_v[0] = 1'b0;
        @(negedge clk);
        check_bit("reset busy ready", b8.mem_ready, 1'b0);
        check_val("reset busy rdata", b8.mem_rdata, '0);
        last_rd = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        model_apply(1'b1, 1'b0, 28'h40, '0, e);
        txn(1'b1, 1'b0, 28'h40, '0, 0, e, "reset busy readback");

        // Reset during RESP drops mem_ready on the next edge.
        rd_v[0] = 1'b1;
        addr    = 28'h10;
        n   = 0;
        got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (b8.mem_ready) got = 1;
        end
        check_int("resp reset latency", got ? n : -1, 8);
        check_val("resp reset rdata", b8.mem_rdata, D0);
        rst_n   = 1'b0;
        rd_v[0] = 1'b0;
        @(negedge clk);
        check_bit("reset resp ready", b8.mem_ready, 1'b0);
        check_val("reset resp rdata", b8.mem_rdata, '0);
        last_rd = '0;
        rst_n   = 1'b1;
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            a  = 28'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            if (op == 0 && known.size() > 0) begin
                a[11:4] = 8'(known[$urandom_range(0, known.size() - 1)]);
                model_apply(1'b1, 1'b0, a, '0, e);
                txn(1'b1, 1'b0, a, d, 0, e, $sformatf("rnd%0d read", i));
            end else begin
                model_apply(op == 2, 1'b1, a, d, e);
                txn(op == 2, 1'b1, a, d, 0, e, $sformatf("rnd%0d write", i));
            end
        end

        lat_meas(1, 1, "lat1");
        lat_meas(2, 255, "lat255");

        // Held request on LATENCY=1: ready, RESP->GAP->IDLE, re-accept.
        wr_v[1] = 1'b1;
        addr    = 28'h2;
        wdata   = D1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_bit($sformatf("held lat1 cyc%0d", i), b1.mem_ready,
                      ((i - 1) % (1 + 2)) == 0);
        end
        wr_v[1] = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
